// File: rtl/alarm_scheduler.sv
// alarm_scheduler: debounced smoke/power monitor with latched alarm, silence window and blinking fault siren
module alarm_scheduler_debounce #(
    parameter int   CYCLES     = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int W = $clog2(CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         level_q, level_d;

    // count consecutive samples that disagree with the accepted level; accept on the last one
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (raw != level_q) begin
            if (cnt_q == LAST) level_d = raw;
            else               cnt_d   = cnt_q + ONE;
        end
    end

    // debouncer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
endmodule

module alarm_scheduler #(
    parameter int DEB_CYCLES     = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int SILENCE_CYCLES = 16,
    parameter int BLINK_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_ok,
    input  logic       humo,
    input  logic       ack,
    output logic       luz_ok,
    output logic       luz_warn,
    output logic       luz_fault,
    output logic       alarma_humo,
    output logic       alarma_power,
    output logic [2:0] state
);
    localparam int TMAX = (CONFIRM_CYCLES > SILENCE_CYCLES) ? CONFIRM_CYCLES : SILENCE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] CONF_LAST = TW'(CONFIRM_CYCLES - 1);
    localparam logic [TW-1:0] SIL_LAST  = TW'(SILENCE_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_CYCLES - 1);
    localparam logic [BW-1:0] B_ONE     = BW'(1);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        MONITOR  = 3'd1,
        CONFIRM  = 3'd2,
        ALARM    = 3'd3,
        SILENCED = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          hs_db, pw_db;
    logic          supervised;

    alarm_scheduler_debounce #(.CYCLES(DEB_CYCLES), .INIT_LEVEL(1'b0)) u_hs_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (humo),
        .level (hs_db)
    );

    alarm_scheduler_debounce #(.CYCLES(DEB_CYCLES), .INIT_LEVEL(1'b1)) u_pw_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (power_ok),
        .level (pw_db)
    );

    assign supervised = (state_q == MONITOR) || (state_q == CONFIRM) ||
                        (state_q == ALARM)   || (state_q == SILENCED);

    // next-state and shared timer; loss of power overrides every smoke transition
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            INIT:     state_d = MONITOR;
            MONITOR:  if (hs_db) begin
                          state_d = CONFIRM;
                          timer_d = '0;
                      end
            CONFIRM:  if (!hs_db)                 state_d = MONITOR;
                      else if (timer_q == CONF_LAST) state_d = ALARM;
                      else                        timer_d = timer_q + T_ONE;
            ALARM:    if (ack) begin
                          state_d = SILENCED;
                          timer_d = '0;
                      end
            SILENCED: if (!hs_db)                 state_d = MONITOR;
                      else if (timer_q == SIL_LAST) state_d = ALARM;
                      else                        timer_d = timer_q + T_ONE;
            FAULT:    if (pw_db) begin
                          state_d = MONITOR;
                          timer_d = '0;
                      end
            default:  state_d = INIT;
        endcase
        if (supervised && !pw_db) state_d = FAULT;
    end

    // blink generator armed at 1 outside FAULT so the siren starts high on entry
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = '0;
        if (state_q != FAULT) blink_d = 1'b1;
        else if (blink_cnt_q == BL_LAST) blink_d = ~blink_q;
        else blink_cnt_d = blink_cnt_q + B_ONE;
    end

    // state, timer and blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            timer_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Moore decode of the state register
    always_comb begin
        luz_ok       = (state_q == MONITOR);
        luz_warn     = (state_q == CONFIRM) || (state_q == ALARM) || (state_q == SILENCED);
        luz_fault    = (state_q == FAULT);
        alarma_humo  = (state_q == ALARM);
        alarma_power = (state_q == FAULT) ? blink_q : 1'b0;
        state        = state_q;
    end
endmodule
